// File: rtl/gate_chk_pkg.sv
// Shared definitions for the 2-input gate checker: gate select codes, FSM states
// and the truth-table function used as the golden reference.
package gate_chk_pkg;

    localparam logic [2:0] SEL_AND  = 3'd0;
    localparam logic [2:0] SEL_OR   = 3'd1;
    localparam logic [2:0] SEL_NAND = 3'd2;
    localparam logic [2:0] SEL_NOR  = 3'd3;
    localparam logic [2:0] SEL_XOR  = 3'd4;
    localparam logic [2:0] SEL_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // vec is {in1,in2}; illegal selects return 0 and are screened out by sel_legal.
    function automatic logic expected(input logic [2:0] sel, input logic [1:0] vec);
        logic a;
        logic b;
        a = vec[1];
        b = vec[0];
        case (sel)
            SEL_AND:  return a & b;
            SEL_OR:   return a | b;
            SEL_NAND: return ~(a & b);
            SEL_NOR:  return ~(a | b);
            SEL_XOR:  return a ^ b;
            SEL_XNOR: return ~(a ^ b);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic sel_legal(input logic [2:0] sel);
        return sel <= SEL_XNOR;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: expected output of the selected 2-input gate.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic [2:0] sel_i,
    input  logic       in1_i,
    input  logic       in2_i,
    output logic       y_o
);

    assign y_o = expected(sel_i, {in1_i, in2_i});

endmodule

// File: rtl/gate_checker.sv
// BIST-style exerciser: drives 00,01,10,11 onto a gate under test, samples y after
// SETTLE_CYCLES per vector and reports pass, mismatch count and first failing vector.
module gate_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] gate_sel_i,
    output logic       in1_o,
    output logic       in2_o,
    input  logic       y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] err_count_o,
    output logic [1:0] first_fail_o,
    output logic       sel_err_o
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q;
    logic [2:0] sel_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic [1:0] in_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic [1:0] ff_q;
    logic       sel_err_q;

    logic       exp_y;
    logic       mismatch;
    logic [2:0] err_d;

    gate_ref_model u_ref (
        .sel_i (sel_q),
        .in1_i (vec_q[1]),
        .in2_i (vec_q[0]),
        .y_o   (exp_y)
    );

    assign mismatch = (y_i != exp_y);
    // Count including the vector being sampled now, so pass can be set on the last sample edge.
    assign err_d    = err_q + {2'b00, mismatch};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            vec_q     <= 2'd0;
            cnt_q     <= 4'd0;
            in_q      <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 3'd0;
            ff_q      <= 2'd0;
            sel_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_q <= 2'd0;
                    if (start_i) begin
                        sel_q  <= gate_sel_i;
                        err_q  <= 3'd0;
                        ff_q   <= 2'd0;
                        pass_q <= 1'b0;
                        busy_q <= 1'b1;
                        vec_q  <= 2'd0;
                        cnt_q  <= 4'd0;
                        if (sel_legal(gate_sel_i)) begin
                            sel_err_q <= 1'b0;
                            state_q   <= ST_DRIVE;
                        end else begin
                            sel_err_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= 4'd0;
                        err_q <= err_d;
                        if (mismatch && (err_q == 3'd0)) begin
                            ff_q <= vec_q;
                        end
                        if (vec_q == 2'd3) begin
                            in_q    <= 2'd0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 3'd0) && !sel_err_q;
                            state_q <= ST_DONE;
                        end else begin
                            vec_q <= vec_q + 2'd1;
                            in_q  <= vec_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    in_q    <= 2'd0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in1_o        = in_q[1];
    assign in2_o        = in_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign first_fail_o = ff_q;
    assign sel_err_o    = sel_err_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: two instances (SETTLE_CYCLES 2 and 1) each driving a
// behavioural gate, checked cycle by cycle against a truth-table reference.
module tb_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a     [2];
    logic       start_a   [2];
    logic [2:0] sel_a     [2];
    logic [2:0] act_a     [2];
    logic       y_a       [2];
    logic       in1_a     [2];
    logic       in2_a     [2];
    logic       busy_a    [2];
    logic       done_a    [2];
    logic       pass_a    [2];
    logic [2:0] err_a     [2];
    logic [1:0] ff_a      [2];
    logic       sel_err_a [2];

    int checks = 0;
    int errors = 0;

    // Truth table indexed by {in1,in2}.
    function automatic logic [3:0] truth(input logic [2:0] g);
        case (g)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic tt_bit(input logic [2:0] g, input logic [1:0] v);
        logic [3:0] t;
        t = truth(g);
        return t[v];
    endfunction

    assign y_a[0] = tt_bit(act_a[0], {in1_a[0], in2_a[0]});
    assign y_a[1] = tt_bit(act_a[1], {in1_a[1], in2_a[1]});

    gate_checker #(.SETTLE_CYCLES(2)) u_s2 (
        .clk_i (clk), .rst_i (rst_a[0]), .start_i (start_a[0]), .gate_sel_i (sel_a[0]),
        .in1_o (in1_a[0]), .in2_o (in2_a[0]), .y_i (y_a[0]), .busy_o (busy_a[0]),
        .done_o (done_a[0]), .pass_o (pass_a[0]), .err_count_o (err_a[0]),
        .first_fail_o (ff_a[0]), .sel_err_o (sel_err_a[0])
    );

    gate_checker #(.SETTLE_CYCLES(1)) u_s1 (
        .clk_i (clk), .rst_i (rst_a[1]), .start_i (start_a[1]), .gate_sel_i (sel_a[1]),
        .in1_o (in1_a[1]), .in2_o (in2_a[1]), .y_i (y_a[1]), .busy_o (busy_a[1]),
        .done_o (done_a[1]), .pass_o (pass_a[1]), .err_count_o (err_a[1]),
        .first_fail_o (ff_a[1]), .sel_err_o (sel_err_a[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int k);
        chk("rst_in",      {6'd0, in1_a[k], in2_a[k]}, 8'd0);
        chk("rst_busy",    {7'd0, busy_a[k]},          8'd0);
        chk("rst_done",    {7'd0, done_a[k]},          8'd0);
        chk("rst_pass",    {7'd0, pass_a[k]},          8'd0);
        chk("rst_err",     {5'd0, err_a[k]},           8'd0);
        chk("rst_ff",      {6'd0, ff_a[k]},            8'd0);
        chk("rst_sel_err", {7'd0, sel_err_a[k]},       8'd0);
    endtask

    // One full run; restart_mid pulses start (with a different select) 4 edges in.
    task automatic run(input int k, input logic [2:0] sel, input logic [2:0] act,
                       input bit restart_mid);
        int         s;
        int         n_mis;
        int         ff;
        bit         legal;
        logic [3:0] diff;
        logic [1:0] v;
        s     = (k == 0) ? 2 : 1;
        legal = (sel <= 3'd5);
        diff  = truth(sel) ^ truth(act);
        n_mis = $countones(diff);
        ff    = 0;
        for (int b = 3; b >= 0; b--) if (diff[b]) ff = b;
        act_a[k] = act;
        @(negedge clk);
        sel_a[k]   = sel;
        start_a[k] = 1'b1;
        @(posedge clk);
        if (legal) begin
            for (int m = 0; m <= 4 * s + 1; m++) begin
                @(negedge clk);
                start_a[k] = 1'b0;
                sel_a[k]   = sel;
                v = (m < 4 * s) ? 2'(m / s) : 2'd0;
                chk("vec",  {6'd0, in1_a[k], in2_a[k]}, {6'd0, v});
                chk("done", {7'd0, done_a[k]}, {7'd0, m == 4 * s});
                chk("busy", {7'd0, busy_a[k]}, {7'd0, m <= 4 * s});
                if (m == 4 * s + 1) begin
                    chk("err_count",  {5'd0, err_a[k]},     8'(n_mis));
                    chk("first_fail", {6'd0, ff_a[k]},      8'(ff));
                    chk("pass",       {7'd0, pass_a[k]},    {7'd0, n_mis == 0});
                    chk("sel_err",    {7'd0, sel_err_a[k]}, 8'd0);
                end
                if (restart_mid && m == 3) begin
                    start_a[k] = 1'b1;
                    sel_a[k]   = 3'($urandom_range(0, 7));
                end
            end
        end else begin
            for (int m = 0; m <= 1; m++) begin
                @(negedge clk);
                start_a[k] = 1'b0;
                chk("ill_vec",     {6'd0, in1_a[k], in2_a[k]}, 8'd0);
                chk("ill_done",    {7'd0, done_a[k]},    {7'd0, m == 0});
                chk("ill_busy",    {7'd0, busy_a[k]},    {7'd0, m == 0});
                chk("ill_sel_err", {7'd0, sel_err_a[k]}, 8'd1);
                chk("ill_pass",    {7'd0, pass_a[k]},    8'd0);
                chk("ill_err",     {5'd0, err_a[k]},     8'd0);
                chk("ill_ff",      {6'd0, ff_a[k]},      8'd0);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_a[k]   = 1'b1;
            start_a[k] = 1'b0;
            sel_a[k]   = 3'd0;
            act_a[k]   = 3'd3;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;

        // Correct NOR, NOR checked as NAND, illegal select, ignored mid-run start.
        run(0, 3'd3, 3'd3, 1'b0);
        run(0, 3'd2, 3'd3, 1'b0);
        run(0, 3'd6, 3'd3, 1'b0);
        run(0, 3'd7, 3'd1, 1'b0);
        run(0, 3'd3, 3'd3, 1'b1);
        run(0, 3'd0, 3'd4, 1'b1);

        // Reset mid-run: abort, no done, then a clean run.
        act_a[0] = 3'd3;
        @(negedge clk);
        sel_a[0]   = 3'd3;
        start_a[0] = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= 5; m++) begin
            @(negedge clk);
            start_a[0] = 1'b0;
        end
        rst_a[0] = 1'b1;
        @(negedge clk);
        chk_reset_vals(0);
        rst_a[0] = 1'b0;
        for (int m = 0; m < 10; m++) begin
            @(negedge clk);
            chk("no_done_after_rst", {7'd0, done_a[0]}, 8'd0);
        end
        run(0, 3'd3, 3'd3, 1'b0);

        // Single-cycle settle with XOR.
        run(1, 3'd4, 3'd4, 1'b0);
        run(1, 3'd5, 3'd4, 1'b0);
        run(1, 3'd6, 3'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
